maze_walker: RTL and testbench

Parametrised wall-following maze solver, successor to the fixed 64×64 right-hand walker. It drives the same synchronous single-bit maze memory interface: row/col select, `maze_oe` read, `maze_we` visited-marking. It adds configurable maze size, left- or right-hand rule, a start handshake, a step limit with failure reporting, and a step counter. It sits between the maze RAM and the top-level controller.

---
 rtl/maze_pkg.sv | 33 +++
 rtl/maze_nav.sv | 40 ++++
 rtl/maze_walker.sv | 161 ++++++++++++++++
 tb/tb_maze_walker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared definitions for the wall-following maze walker.
//   dir_t      - 2-bit heading, N=0, E=1, S=2, W=3
//   state_t    - walker FSM state code
//   turn_cw    - rotate heading clockwise (N->E->S->W->N)
//   turn_ccw   - rotate heading counter-clockwise
package maze_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_N = 2'd0;
    localparam dir_t DIR_E = 2'd1;
    localparam dir_t DIR_S = 2'd2;
    localparam dir_t DIR_W = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_MARK  = 3'd1;
    localparam state_t ST_PROBE = 3'd2;
    localparam state_t ST_EVAL  = 3'd3;
    localparam state_t ST_MOVE  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;
    localparam state_t ST_FAIL  = 3'd6;

    function automatic dir_t turn_cw(input dir_t d);
        return d + 2'd1;
    endfunction

    function automatic dir_t turn_ccw(input dir_t d);
        return d - 2'd1;
    endfunction

endpackage

// File: rtl/maze_nav.sv
// maze_nav: combinational neighbour / boundary logic.
//   cur_row, cur_col : current cell
//   dir              : heading whose neighbour is wanted
//   nbr_row, nbr_col : neighbour of the current cell in dir
//   at_boundary      : current cell lies on the outer ring of the maze
module maze_nav
    import maze_pkg::*;
#(
    parameter int MAZE_WIDTH = 6,
    parameter int MAZE_ROWS  = 64,
    parameter int MAZE_COLS  = 64
) (
    input  logic [MAZE_WIDTH-1:0] cur_row,
    input  logic [MAZE_WIDTH-1:0] cur_col,
    input  logic [1:0]            dir,
    output logic [MAZE_WIDTH-1:0] nbr_row,
    output logic [MAZE_WIDTH-1:0] nbr_col,
    output logic                  at_boundary
);

    localparam logic [MAZE_WIDTH-1:0] ONE      = MAZE_WIDTH'(1);
    localparam logic [MAZE_WIDTH-1:0] LAST_ROW = MAZE_WIDTH'(MAZE_ROWS - 1);
    localparam logic [MAZE_WIDTH-1:0] LAST_COL = MAZE_WIDTH'(MAZE_COLS - 1);

    // Wrap-around is harmless: the walker never probes from a boundary cell.
    always_comb begin
        nbr_row = cur_row;
        nbr_col = cur_col;
        case (dir)
            DIR_N:   nbr_row = cur_row - ONE;
            DIR_E:   nbr_col = cur_col + ONE;
            DIR_S:   nbr_row = cur_row + ONE;
            default: nbr_col = cur_col - ONE;
        endcase
    end

    assign at_boundary = (cur_row == '0) || (cur_row == LAST_ROW) ||
                         (cur_col == '0) || (cur_col == LAST_COL);

endmodule

// File: rtl/maze_walker.sv
// maze_walker: wall-following maze solver on a synchronous 1-bit maze RAM.
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin a walk (ignored while busy)
//   starting_row/col/dir  : start cell and heading, sampled with start
//   maze_in               : cell content (1 = wall), valid the cycle after maze_oe
//   row, col              : registered cell address for the RAM
//   maze_oe, maze_we      : one-cycle read / visited-mark strobes
//   busy, done, fail      : walk in progress / exit reached / enclosed or step limit
//   step_count            : moves completed in the current walk (saturating)
module maze_walker
    import maze_pkg::*;
#(
    parameter int MAZE_WIDTH = 6,
    parameter int MAZE_ROWS  = 64,
    parameter int MAZE_COLS  = 64,
    parameter int HAND       = 0,
    parameter int MAX_STEPS  = 4096,
    parameter int STEP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MAZE_WIDTH-1:0] starting_row,
    input  logic [MAZE_WIDTH-1:0] starting_col,
    input  logic [1:0]            starting_dir,
    input  logic                  maze_in,
    output logic [MAZE_WIDTH-1:0] row,
    output logic [MAZE_WIDTH-1:0] col,
    output logic                  maze_oe,
    output logic                  maze_we,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [STEP_W-1:0]     step_count
);

    localparam logic [STEP_W-1:0] MAX_C = STEP_W'(MAX_STEPS);

    function automatic dir_t toward(input dir_t d);
        return (HAND == 0) ? turn_cw(d) : turn_ccw(d);
    endfunction

    function automatic dir_t away(input dir_t d);
        return (HAND == 0) ? turn_ccw(d) : turn_cw(d);
    endfunction

    state_t                  state;
    logic [MAZE_WIDTH-1:0]   cur_row, cur_col;
    dir_t                    dir, cand_dir, nxt_cand;
    logic [1:0]              tries;
    logic [MAZE_WIDTH-1:0]   nbr_row, nbr_col;
    logic                    at_boundary;

    // Heading of the probe issued on the next edge; the RAM address is
    // registered, so the neighbour is computed one cycle ahead of PROBE.
    always_comb begin
        nxt_cand = cand_dir;
        case (state)
            ST_MARK, ST_MOVE: nxt_cand = toward(dir);
            ST_EVAL:          nxt_cand = away(cand_dir);
            default:          nxt_cand = cand_dir;
        endcase
    end

    maze_nav #(
        .MAZE_WIDTH (MAZE_WIDTH),
        .MAZE_ROWS  (MAZE_ROWS),
        .MAZE_COLS  (MAZE_COLS)
    ) u_nav (
        .cur_row     (cur_row),
        .cur_col     (cur_col),
        .dir         (nxt_cand),
        .nbr_row     (nbr_row),
        .nbr_col     (nbr_col),
        .at_boundary (at_boundary)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur_row    <= '0;
            cur_col    <= '0;
            dir        <= DIR_N;
            cand_dir   <= DIR_N;
            tries      <= '0;
            row        <= '0;
            col        <= '0;
            maze_oe    <= 1'b0;
            maze_we    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            step_count <= '0;
        end else begin
            maze_oe <= 1'b0;
            maze_we <= 1'b0;
            case (state)
                ST_MARK, ST_MOVE: begin
                    if (at_boundary) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (state == ST_MOVE && step_count == MAX_C) begin
                        state <= ST_FAIL;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cand_dir <= nxt_cand;
                        tries    <= '0;
                        maze_oe  <= 1'b1;
                        row      <= nbr_row;
                        col      <= nbr_col;
                        state    <= ST_PROBE;
                    end
                end
                ST_PROBE: state <= ST_EVAL;
                ST_EVAL: begin
                    if (!maze_in) begin
                        // row/col still hold the probed neighbour: it is the new cell.
                        cur_row <= row;
                        cur_col <= col;
                        dir     <= cand_dir;
                        if (step_count != '1)
                            step_count <= step_count + STEP_W'(1);
                        maze_we <= 1'b1;
                        state   <= ST_MOVE;
                    end else if (tries != 2'd3) begin
                        cand_dir <= nxt_cand;
                        tries    <= tries + 2'd1;
                        maze_oe  <= 1'b1;
                        row      <= nbr_row;
                        col      <= nbr_col;
                        state    <= ST_PROBE;
                    end else begin
                        state <= ST_FAIL;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    // IDLE, DONE, FAIL all accept a new walk.
                    if (start) begin
                        cur_row    <= starting_row;
                        cur_col    <= starting_col;
                        dir        <= starting_dir;
                        tries      <= '0;
                        step_count <= '0;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        busy       <= 1'b1;
                        maze_we    <= 1'b1;
                        row        <= starting_row;
                        col        <= starting_col;
                        state      <= ST_MARK;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_walker.sv
module tb_maze_walker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] s_row = '0, s_col = '0;
    logic [1:0] s_dir = '0;
    logic       start0 = 0, start1 = 0, start2 = 0;
    logic       min0 = 0, min1 = 0, min2 = 0;

    logic [2:0]  row0, col0, row1, col1, row2, col2;
    logic        oe0, we0, busy0, done0, fail0;
    logic        oe1, we1, busy1, done1, fail1;
    logic        oe2, we2, busy2, done2, fail2;
    logic [15:0] sc0, sc1, sc2;

    maze_walker #(.MAZE_WIDTH(3), .MAZE_ROWS(8), .MAZE_COLS(8), .HAND(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .starting_row(s_row), .starting_col(s_col),
        .starting_dir(s_dir), .maze_in(min0), .row(row0), .col(col0), .maze_oe(oe0), .maze_we(we0),
        .busy(busy0), .done(done0), .fail(fail0), .step_count(sc0));

    maze_walker #(.MAZE_WIDTH(3), .MAZE_ROWS(8), .MAZE_COLS(8), .HAND(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .starting_row(s_row), .starting_col(s_col),
        .starting_dir(s_dir), .maze_in(min1), .row(row1), .col(col1), .maze_oe(oe1), .maze_we(we1),
        .busy(busy1), .done(done1), .fail(fail1), .step_count(sc1));

    maze_walker #(.MAZE_WIDTH(3), .MAZE_ROWS(8), .MAZE_COLS(8), .HAND(0), .MAX_STEPS(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .starting_row(s_row), .starting_col(s_col),
        .starting_dir(s_dir), .maze_in(min2), .row(row2), .col(col2), .maze_oe(oe2), .maze_we(we2),
        .busy(busy2), .done(done2), .fail(fail2), .step_count(sc2));

    // Synchronous maze RAM model shared by all three walkers.
    logic wall [0:7][0:7];
    always @(posedge clk) begin
        if (oe0) min0 <= wall[row0][col0];
        if (oe1) min1 <= wall[row1][col1];
        if (oe2) min2 <= wall[row2][col2];
    end

    logic [5:0] we_log[$], oe_log[$];
    int overlap = 0;
    always @(negedge clk) begin
        if (we0) we_log.push_back({row0, col0});
        if (oe0) oe_log.push_back({row0, col0});
        if (we1) we_log.push_back({row1, col1});
        if (oe1) oe_log.push_back({row1, col1});
        if (we2) we_log.push_back({row2, col2});
        if (oe2) oe_log.push_back({row2, col2});
        if ((oe0 && we0) || (oe1 && we1) || (oe2 && we2)) overlap++;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] pk(input int r, input int c);
        return 6'(r * 8 + c);
    endfunction

    task automatic all_walls();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) wall[r][c] = 1'b1;
    endtask

    task automatic corridor();
        all_walls();
        for (int c = 3; c < 8; c++) wall[3][c] = 1'b0;
    endtask

    // Starts a walk on instance inst; returns at the negedge of cycle k+1.
    task automatic go(input int inst, input int r, input int c, input int d);
        @(negedge clk);
        s_row = 3'(r); s_col = 3'(c); s_dir = 2'(d);
        case (inst)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    // Counts negedges until instance inst shows done or fail (bounded).
    task automatic wait_end(input int inst, output int cnt);
        logic fin;
        cnt = 0;
        forever begin
            case (inst)
                0: fin = done0 | fail0;
                1: fin = done1 | fail1;
                default: fin = done2 | fail2;
            endcase
            if (fin || cnt >= 300) break;
            @(negedge clk);
            cnt++;
        end
        check("walk_terminates", 32'(fin), 32'd1);
    endtask

    int cnt;

    initial begin
        all_walls();
        #23;
        check("reset_outputs", {26'(0), oe0, we0, busy0, done0, fail0, 1'b0},  32'd0);
        check("reset_addr_steps", {row0, col0, sc0}, 32'd0);
        rst_n = 1'b1;

        // Enclosed start: probes S, E, N, W then fail at k+10.
        we_log.delete(); oe_log.delete();
        go(0, 3, 3, 1);
        check("enc_mark", {we0, oe0, busy0, row0, col0}, {1'b1, 1'b0, 1'b1, 3'd3, 3'd3});
        wait_end(0, cnt);
        check("enc_latency", cnt, 32'd9);
        check("enc_flags", {done0, fail0, busy0}, 3'b010);
        check("enc_steps", sc0, 32'd0);
        check("enc_nprobes", oe_log.size(), 32'd4);
        if (oe_log.size() == 4) begin
            check("enc_p0_S", oe_log[0], pk(4, 3));
            check("enc_p1_E", oe_log[1], pk(3, 4));
            check("enc_p2_N", oe_log[2], pk(2, 3));
            check("enc_p3_W", oe_log[3], pk(3, 2));
        end

        // Corridor, right hand.
        corridor();
        we_log.delete(); oe_log.delete();
        go(0, 3, 3, 1);
        wait_end(0, cnt);
        check("cor_latency", cnt, 32'd21);
        check("cor_flags", {done0, fail0, busy0}, 3'b100);
        check("cor_steps", sc0, 32'd4);
        check("cor_nmarks", we_log.size(), 32'd5);
        for (int i = 0; i < 5 && i < we_log.size(); i++)
            check("cor_mark", we_log[i], pk(3, 3 + i));
        check("cor_nprobes", oe_log.size(), 32'd8);
        if (oe_log.size() == 8) begin
            check("cor_p0_S", oe_log[0], pk(4, 3));
            check("cor_p1_E", oe_log[1], pk(3, 4));
            check("cor_p6_S", oe_log[6], pk(4, 6));
        end

        // Corridor, left hand: N first, then E.
        we_log.delete(); oe_log.delete();
        go(1, 3, 3, 1);
        wait_end(1, cnt);
        check("mir_latency", cnt, 32'd21);
        check("mir_flags", {done1, fail1, busy1}, 3'b100);
        check("mir_steps", sc1, 32'd4);
        check("mir_nprobes", oe_log.size(), 32'd8);
        if (oe_log.size() == 8) begin
            check("mir_p0_N", oe_log[0], pk(2, 3));
            check("mir_p1_E", oe_log[1], pk(3, 4));
            check("mir_p2_N", oe_log[2], pk(2, 4));
        end

        // Step limit of 3.
        we_log.delete(); oe_log.delete();
        go(2, 3, 3, 1);
        wait_end(2, cnt);
        check("lim_latency", cnt, 32'd16);
        check("lim_flags", {done2, fail2, busy2}, 3'b010);
        check("lim_steps", sc2, 32'd3);
        check("lim_nmarks", we_log.size(), 32'd4);
        if (we_log.size() == 4) check("lim_last_mark", we_log[3], pk(3, 6));

        // Boundary start, restarted from DONE.
        we_log.delete(); oe_log.delete();
        go(0, 0, 5, 0);
        check("bnd_mark", {we0, busy0, done0, row0, col0}, {1'b1, 1'b1, 1'b0, 3'd0, 3'd5});
        wait_end(0, cnt);
        check("bnd_latency", cnt, 32'd1);
        check("bnd_flags", {done0, fail0, busy0}, 3'b100);
        check("bnd_noprobe", oe_log.size(), 32'd0);
        check("bnd_steps", sc0, 32'd0);

        // Reset mid-walk.
        go(0, 3, 3, 1);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {oe0, we0, busy0, done0, fail0}, 5'b0);
        check("rst_mid_addr", {row0, col0, sc0}, 32'd0);
        we_log.delete(); oe_log.delete();
        repeat (2) @(negedge clk);
        check("rst_no_strobe", we_log.size() + oe_log.size(), 32'd0);
        rst_n = 1'b1;

        // Restart, with an ignored start while busy.
        we_log.delete(); oe_log.delete();
        go(0, 3, 3, 1);
        repeat (3) @(negedge clk);
        go(0, 0, 0, 0);
        check("busy_ignore", {busy0, row0 == 3'd0 && col0 == 3'd0}, 2'b10);
        wait_end(0, cnt);
        check("rerun_flags", {done0, fail0, busy0}, 3'b100);
        check("rerun_steps", sc0, 32'd4);
        check("rerun_nmarks", we_log.size(), 32'd5);
        if (we_log.size() > 0) check("rerun_first_mark", we_log[0], pk(3, 3));

        check("oe_we_exclusive", overlap, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
